// File: rtl/hsst_rst_wtchdg_mc.sv
// rtl/hsst_rst_wtchdg_mc.sv - per-lane HSST reset watchdog with bounded retries and sticky fail
// Optional 2-flop wtchdg_ok synchroniser enabled by defining HSST_WTCHDG_SYNC_EN.
module hsst_rst_wtchdg_mc #(
  parameter int CH_NUM      = 4,
  parameter int OK_ACT_HIGH = 1,
  parameter int TIMEOUT_CYC = 262144,
  parameter int RST_LEN     = 512,
  parameter int MAX_RETRY   = 7,
  parameter int TW          = $clog2(TIMEOUT_CYC + 1),
  parameter int LW          = $clog2(RST_LEN + 1),
  parameter int RW          = $clog2(MAX_RETRY + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CH_NUM-1:0]    wtchdg_clr,
  input  logic [CH_NUM-1:0]    wtchdg_ok,
  output logic [CH_NUM-1:0]    wtchdg_rst_n,
  output logic [CH_NUM-1:0]    wtchdg_fail,
  output logic                 any_fail,
  output logic [CH_NUM*RW-1:0] retry_cnt
);

  typedef enum logic [1:0] {ST_MON, ST_FIRE, ST_FAIL} state_t;

  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [LW-1:0] L_LAST = LW'(RST_LEN - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

  logic [CH_NUM-1:0] ok_norm;
  logic [CH_NUM-1:0] ok_i;
  logic [CH_NUM-1:0] fail_nxt;

  assign ok_norm = (OK_ACT_HIGH != 0) ? wtchdg_ok : ~wtchdg_ok;

`ifdef HSST_WTCHDG_SYNC_EN
  logic [CH_NUM-1:0] ok_s1;
  logic [CH_NUM-1:0] ok_s2;

  // Synchroniser resets to "not ok" so a lane never looks healthy before it has been sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_s1 <= '0;
      ok_s2 <= '0;
    end else begin
      ok_s1 <= ok_norm;
      ok_s2 <= ok_s1;
    end
  end

  assign ok_i = ok_s2;
`else
  assign ok_i = ok_norm;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_lane
      state_t        state;
      logic [TW-1:0] tcnt;
      logic [LW-1:0] lcnt;
      logic [RW-1:0] retry_q;
      logic          rst_q;
      logic          fail_q;
      logic          timeout;

      assign timeout = (state == ST_MON) && !ok_i[gi] && (tcnt == T_LAST);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state   <= ST_MON;
          tcnt    <= '0;
          lcnt    <= '0;
          retry_q <= '0;
          rst_q   <= 1'b1;
          fail_q  <= 1'b0;
        end else if (wtchdg_clr[gi]) begin
          state   <= ST_MON;
          tcnt    <= '0;
          lcnt    <= '0;
          retry_q <= '0;
          rst_q   <= 1'b1;
          fail_q  <= 1'b0;
        end else begin
          case (state)
            ST_MON: begin
              if (ok_i[gi]) begin
                tcnt    <= '0;
                retry_q <= '0;
              end else if (timeout) begin
                tcnt <= '0;
                if (retry_q == R_MAX) begin
                  state  <= ST_FAIL;
                  fail_q <= 1'b1;
                end else begin
                  state   <= ST_FIRE;
                  retry_q <= retry_q + RW'(1);
                  rst_q   <= 1'b0;
                  lcnt    <= '0;
                end
              end else begin
                tcnt <= tcnt + TW'(1);
              end
            end
            ST_FIRE: begin
              // Pulse started at the timeout edge, so RST_LEN-1 further edges complete it.
              if (lcnt == L_LAST) begin
                state <= ST_MON;
                rst_q <= 1'b1;
                tcnt  <= '0;
                lcnt  <= '0;
              end else begin
                lcnt <= lcnt + LW'(1);
              end
            end
            ST_FAIL: begin
              fail_q <= 1'b1;
              rst_q  <= 1'b1;
            end
            default: begin
              state  <= ST_MON;
              tcnt   <= '0;
              lcnt   <= '0;
              rst_q  <= 1'b1;
              fail_q <= 1'b0;
            end
          endcase
        end
      end

      assign fail_nxt[gi] = !wtchdg_clr[gi] &&
                            ((state == ST_FAIL) || (timeout && (retry_q == R_MAX)));

      assign wtchdg_rst_n[gi]          = rst_q;
      assign wtchdg_fail[gi]           = fail_q;
      assign retry_cnt[gi*RW +: RW]    = retry_q;
    end
  endgenerate

  // Built from the next-state vector so it moves on the same edge as wtchdg_fail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_fail <= 1'b0;
    end else begin
      any_fail <= |fail_nxt;
    end
  end

endmodule
